fp_sgnj_arbiter: RTL and testbench

Shares one sign-injection datapath (FSGNJ/FSGNJN/FSGNJX, single and double precision) between two requesters: the FP issue lane (port 0) and the FP microcode sequencer (port 1).
- Round-robin arbitration at the input.
- Valid/ready handshakes on both inputs and on the output.
- One registered output slot, so latency is 1 cycle.
- Sits between FP issue and the FP result writeback mux.

---
 rtl/fp_pkg.sv | 32 +++
 rtl/fp_sgnj_kernel.sv | 45 ++++
 rtl/fp_sgnj_arbiter.sv | 100 ++++++++++
 tb/tb_fp_sgnj_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP sign-injection op/format constants, request type and sign helper
package fp_pkg;

    localparam logic [1:0]  SGNJ_OP_INJ  = 2'b00;
    localparam logic [1:0]  SGNJ_OP_NEG  = 2'b01;
    localparam logic [1:0]  SGNJ_OP_XOR  = 2'b10;
    localparam logic [1:0]  SGNJ_OP_PASS = 2'b11;

    localparam logic        FMT_SP = 1'b0;
    localparam logic        FMT_DP = 1'b1;

    localparam logic [31:0] SP_CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] NANBOX_ONES  = 32'hFFFFFFFF;

    typedef struct packed {
        logic [63:0] num_a;
        logic [63:0] num_b;
        logic [1:0]  ctrl;
        logic        fmt;
    } sgnj_req_t;

    // Result sign for the three injecting ops; PASS never consults it.
    function automatic logic sgnj_sign(input logic [1:0] ctrl, input logic sa, input logic sb);
        case (ctrl)
            SGNJ_OP_INJ: sgnj_sign = sb;
            SGNJ_OP_NEG: sgnj_sign = ~sb;
            SGNJ_OP_XOR: sgnj_sign = sa ^ sb;
            default:     sgnj_sign = sa;
        endcase
    endfunction

endpackage

// File: rtl/fp_sgnj_kernel.sv
// rtl/fp_sgnj_kernel.sv - combinational FSGNJ/FSGNJN/FSGNJX evaluation (optional FP_SGNJ_NANBOX_CHK_EN)
module fp_sgnj_kernel
    import fp_pkg::*;
(
    input  sgnj_req_t   req,
    output logic [63:0] result
);

    logic [63:0] a_chk;
    logic [63:0] b_chk;
    logic        sa;
    logic        sb;
    logic        rs;
    logic        unused_bits;

    // Improperly boxed single operands are replaced by the canonical NaN when checking is enabled.
    always_comb begin
`ifdef FP_SGNJ_NANBOX_CHK_EN
        a_chk = (req.fmt == FMT_SP && req.num_a[63:32] != NANBOX_ONES)
              ? {NANBOX_ONES, SP_CANON_NAN} : req.num_a;
        b_chk = (req.fmt == FMT_SP && req.num_b[63:32] != NANBOX_ONES)
              ? {NANBOX_ONES, SP_CANON_NAN} : req.num_b;
`else
        a_chk = req.num_a;
        b_chk = req.num_b;
`endif
    end

    // Sign selection and result assembly; PASS forwards the raw A operand untouched.
    always_comb begin
        sa = (req.fmt == FMT_DP) ? a_chk[63] : a_chk[31];
        sb = (req.fmt == FMT_DP) ? b_chk[63] : b_chk[31];
        rs = sgnj_sign(req.ctrl, sa, sb);
        if (req.ctrl == SGNJ_OP_PASS) begin
            result = req.num_a;
        end else if (req.fmt == FMT_DP) begin
            result = {rs, a_chk[62:0]};
        end else begin
            result = {NANBOX_ONES, rs, a_chk[30:0]};
        end
    end

    assign unused_bits = ^b_chk;

endmodule

// File: rtl/fp_sgnj_arbiter.sv
// rtl/fp_sgnj_arbiter.sv - two-port round-robin front end with one registered result slot (optional FP_SGNJ_NANBOX_CHK_EN)
module fp_sgnj_arbiter
    import fp_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int RR_INIT = 0
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_flush,
    input  logic             in_req0_valid,
    output logic             out_req0_ready,
    input  logic [63:0]      in_req0_numA,
    input  logic [63:0]      in_req0_numB,
    input  logic [1:0]       in_req0_ctrl,
    input  logic             in_req0_fmt,
    input  logic [TAG_W-1:0] in_req0_tag,
    input  logic             in_req1_valid,
    output logic             out_req1_ready,
    input  logic [63:0]      in_req1_numA,
    input  logic [63:0]      in_req1_numB,
    input  logic [1:0]       in_req1_ctrl,
    input  logic             in_req1_fmt,
    input  logic [TAG_W-1:0] in_req1_tag,
    output logic             out_valid,
    input  logic             in_out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_src
);

    localparam logic PTR_INIT = (RR_INIT != 0);

    logic             ptr;
    logic             slot_free;
    logic             grant_any;
    logic             winner;
    sgnj_req_t        sel_req;
    logic [TAG_W-1:0] sel_tag;
    logic [63:0]      kernel_result;

    // Grant: the slot must be free, no flush, and reset released; ties go to the pointer.
    always_comb begin
        slot_free = !out_valid || in_out_ready;
        grant_any = 1'b0;
        winner    = ptr;
        if (in_rst_n && slot_free && !in_flush) begin
            if (in_req0_valid && in_req1_valid) begin
                grant_any = 1'b1;
                winner    = ptr;
            end else if (in_req0_valid) begin
                grant_any = 1'b1;
                winner    = 1'b0;
            end else if (in_req1_valid) begin
                grant_any = 1'b1;
                winner    = 1'b1;
            end
        end
        out_req0_ready = grant_any && (winner == 1'b0);
        out_req1_ready = grant_any && (winner == 1'b1);
    end

    // Steer the winning port's operands into the shared kernel.
    always_comb begin
        if (winner) begin
            sel_req = '{num_a: in_req1_numA, num_b: in_req1_numB, ctrl: in_req1_ctrl, fmt: in_req1_fmt};
            sel_tag = in_req1_tag;
        end else begin
            sel_req = '{num_a: in_req0_numA, num_b: in_req0_numB, ctrl: in_req0_ctrl, fmt: in_req0_fmt};
            sel_tag = in_req0_tag;
        end
    end

    fp_sgnj_kernel u_kernel (
        .req    (sel_req),
        .result (kernel_result)
    );

    // Output slot and priority pointer; flush wins over both consume and new grant.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_src   <= 1'b0;
            ptr       <= PTR_INIT;
        end else if (in_flush) begin
            out_valid <= 1'b0;
        end else if (grant_any) begin
            out_valid <= 1'b1;
            out_data  <= kernel_result;
            out_tag   <= sel_tag;
            out_src   <= winner;
            ptr       <= ~winner;
        end else if (in_out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_sgnj_arbiter.sv
// tb/tb_fp_sgnj_arbiter.sv - self-checking bench for fp_sgnj_arbiter with a behavioural reference model
module tb_fp_sgnj_arbiter;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             v0, v1, r0, r1;
    logic [63:0]      a0, b0, a1, b1;
    logic [1:0]       c0, c1;
    logic             f0, f1;
    logic [TAG_W-1:0] t0, t1;
    logic             o_valid, o_ready, o_src;
    logic [63:0]      o_data;
    logic [TAG_W-1:0] o_tag;

    int checks   = 0;
    int failures = 0;

    logic             m_valid;
    logic [63:0]      m_data;
    logic [TAG_W-1:0] m_tag;
    logic             m_src;
    logic             m_ptr;
    logic             last_r0, last_r1;

    fp_sgnj_arbiter #(.TAG_W(TAG_W), .RR_INIT(0)) dut (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_flush      (flush),
        .in_req0_valid (v0),
        .out_req0_ready(r0),
        .in_req0_numA  (a0),
        .in_req0_numB  (b0),
        .in_req0_ctrl  (c0),
        .in_req0_fmt   (f0),
        .in_req0_tag   (t0),
        .in_req1_valid (v1),
        .out_req1_ready(r1),
        .in_req1_numA  (a1),
        .in_req1_numB  (b1),
        .in_req1_ctrl  (c1),
        .in_req1_fmt   (f1),
        .in_req1_tag   (t1),
        .out_valid     (o_valid),
        .in_out_ready  (o_ready),
        .out_data      (o_data),
        .out_tag       (o_tag),
        .out_src       (o_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference sign injection from the op definitions: pick the sign, keep A's magnitude.
    function automatic logic [63:0] ref_sgnj(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] op, input logic dbl);
        logic [63:0] aa, bb;
        logic        sa, sb, s;
        if (op == 2'd3) return a;
        aa = a;
        bb = b;
`ifdef FP_SGNJ_NANBOX_CHK_EN
        if (!dbl && a[63:32] != 32'hFFFFFFFF) aa = 64'hFFFFFFFF_7FC00000;
        if (!dbl && b[63:32] != 32'hFFFFFFFF) bb = 64'hFFFFFFFF_7FC00000;
`endif
        sa = dbl ? aa[63] : aa[31];
        sb = dbl ? bb[63] : bb[31];
        if (op == 2'd0)      s = sb;
        else if (op == 2'd1) s = !sb;
        else                 s = (sa != sb);
        if (dbl) return {s, aa[62:0]};
        return {32'hFFFFFFFF, s, aa[30:0]};
    endfunction

    task automatic set_req(input int p, input logic v, input logic [63:0] a, input logic [63:0] b,
                           input logic [1:0] c, input logic f, input logic [TAG_W-1:0] t);
        if (p == 0) begin v0 = v; a0 = a; b0 = b; c0 = c; f0 = f; t0 = t; end
        else        begin v1 = v; a1 = a; b1 = b; c1 = c; f1 = f; t1 = t; end
    endtask

    // One clock: inputs are already set at the falling edge; check readys, advance model, check outputs.
    task automatic step();
        int          w;
        logic        nv;
        logic [63:0] nd;
        logic [TAG_W-1:0] nt;
        logic        ns, np;
        #1;
        w = -1;
        if (!flush && (!m_valid || o_ready)) begin
            if (v0 && v1) w = m_ptr ? 1 : 0;
            else if (v0)  w = 0;
            else if (v1)  w = 1;
        end
        last_r0 = r0;
        last_r1 = r1;
        check("ready0", {63'd0, r0}, {63'd0, w == 0});
        check("ready1", {63'd0, r1}, {63'd0, w == 1});
        nv = m_valid; nd = m_data; nt = m_tag; ns = m_src; np = m_ptr;
        if (flush) nv = 0;
        else if (w == 0) begin nv = 1; nd = ref_sgnj(a0, b0, c0, f0); nt = t0; ns = 0; np = 1; end
        else if (w == 1) begin nv = 1; nd = ref_sgnj(a1, b1, c1, f1); nt = t1; ns = 1; np = 0; end
        else if (o_ready) nv = 0;
        @(posedge clk);
        #1;
        m_valid = nv; m_data = nd; m_tag = nt; m_src = ns; m_ptr = np;
        check("out_valid", {63'd0, o_valid}, {63'd0, m_valid});
        if (m_valid) begin
            check("out_data", o_data, m_data);
            check("out_tag", {59'd0, o_tag}, {59'd0, m_tag});
            check("out_src", {63'd0, o_src}, {63'd0, m_src});
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_tag = '0; m_src = 0; m_ptr = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, {63'd0, o_valid}, 64'd0);
        check({name, "_data"}, o_data, 64'd0);
        check({name, "_tag"}, {59'd0, o_tag}, 64'd0);
        check({name, "_src"}, {63'd0, o_src}, 64'd0);
        check({name, "_ready0"}, {63'd0, r0}, 64'd0);
        check({name, "_ready1"}, {63'd0, r1}, 64'd0);
    endtask

    initial begin
        logic [63:0]      held_data;
        logic [TAG_W-1:0] held_tag;
        int               exp_src [4] = '{0, 1, 0, 1};

        rst_n = 0; flush = 0; o_ready = 1;
        set_req(0, 1, 64'h3FF0000000000000, 64'h0, 2'd0, 1'b1, 5'd1);
        set_req(1, 1, 64'h0, 64'h0, 2'd0, 1'b1, 5'd2);
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;

        // Port 0 alone, double precision inject
        set_req(0, 1, 64'h3FF0000000000000, 64'h8000000000000000, 2'd0, 1'b1, 5'd3);
        set_req(1, 0, 64'h0, 64'h0, 2'd0, 1'b0, 5'd0);
        step();
        check("dp_inj_data", o_data, 64'hBFF0000000000000);
        check("dp_inj_tag", {59'd0, o_tag}, 64'd3);
        check("dp_inj_src", {63'd0, o_src}, 64'd0);

        // Port 1 alone, single precision XOR then negated inject
        set_req(0, 0, 64'h0, 64'h0, 2'd0, 1'b0, 5'd0);
        set_req(1, 1, 64'hFFFFFFFF_C0400000, 64'hFFFFFFFF_C0000000, 2'd2, 1'b0, 5'd7);
        step();
        check("sp_xor_data", o_data, 64'hFFFFFFFF_40400000);
        check("sp_xor_src", {63'd0, o_src}, 64'd1);
        c1 = 2'd1;
        step();
        check("sp_neg_data", o_data, 64'hFFFFFFFF_40400000);

        // Both ports continuously valid: alternate 0,1,0,1
        set_req(0, 1, 64'h4000000000000000, 64'h8000000000000000, 2'd1, 1'b1, 5'd10);
        set_req(1, 1, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_80000000, 2'd0, 1'b0, 5'd11);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_src", {63'd0, o_src}, exp_src[i]);
            check("rr_one_ready", 64'(last_r0) + 64'(last_r1), 64'd1);
        end

        // Consumer stall: slot held, nothing accepted
        o_ready = 0;
        held_data = o_data;
        held_tag  = o_tag;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_data", o_data, held_data);
            check("hold_tag", {59'd0, o_tag}, {59'd0, held_tag});
            check("hold_no_ready", {62'd0, last_r1, last_r0}, 64'd0);
        end
        o_ready = 1;
        step();
        check("hold_release_valid", {63'd0, o_valid}, 64'd1);

        // Flush with a valid slot and port 0 requesting
        set_req(1, 0, 64'h0, 64'h0, 2'd0, 1'b0, 5'd0);
        flush = 1;
        step();
        check("flush_no_ready", {62'd0, last_r1, last_r0}, 64'd0);
        check("flush_valid", {63'd0, o_valid}, 64'd0);
        flush = 0;
        set_req(1, 1, 64'hFFFFFFFF_12345678, 64'hFFFFFFFF_FFFFFFFF, 2'd2, 1'b0, 5'd12);
        step();

        // Asynchronous reset mid-stream
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1;

        // Improperly boxed single operand
        set_req(0, 0, 64'h0, 64'h0, 2'd0, 1'b0, 5'd0);
        set_req(1, 1, 64'h00000000_3F800000, 64'hFFFFFFFF_80000000, 2'd0, 1'b0, 5'd9);
        step();
`ifdef FP_SGNJ_NANBOX_CHK_EN
        check("nanbox_data", o_data, 64'hFFFFFFFF_FFC00000);
`else
        check("nanbox_data", o_data, 64'hFFFFFFFF_BF800000);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [63:0] ra0, rb0, ra1, rb1;
            logic        rf0, rf1;
            rf0 = 1'($urandom_range(0, 1));
            rf1 = 1'($urandom_range(0, 1));
            ra0 = {$urandom, $urandom}; rb0 = {$urandom, $urandom};
            ra1 = {$urandom, $urandom}; rb1 = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin ra0[63:32] = '1; rb0[63:32] = '1; end
            if ($urandom_range(0, 1) == 1) begin ra1[63:32] = '1; rb1[63:32] = '1; end
            set_req(0, $urandom_range(0, 3) != 0, ra0, rb0, 2'($urandom_range(0, 3)), rf0, 5'($urandom));
            set_req(1, $urandom_range(0, 3) != 0, ra1, rb1, 2'($urandom_range(0, 3)), rf1, 5'($urandom));
            o_ready = $urandom_range(0, 3) != 0;
            flush   = $urandom_range(0, 15) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
